instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_fifo.sv | 48 ++++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: fetch geometry,
// memory size default and the fetch-control state encoding.
package instr_fetch_pkg;

  localparam int unsigned INSTR_BYTES        = 4;
  localparam int unsigned IMEM_BYTES_DEFAULT = 64;
  localparam int unsigned PC_W               = 64;
  localparam int unsigned INSTR_W            = 32;
  localparam int unsigned ENTRY_W            = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    END   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Two-entry FIFO holding {pc, instr} pairs between fetch and decode.
// Only the occupancy/pointer control is reset; the payload storage is not.
module fetch_fifo #(
  parameter int unsigned DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  output logic [1:0]        count,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem_q [2];
  logic              head_q;
  logic [1:0]        count_q;
  logic              wr_idx;

  // Tail slot is head + count (mod 2); with count=2 and a pop, the slot
  // being vacated by the head receives the new entry, preserving order.
  assign wr_idx    = head_q ^ count_q[0];
  assign count     = count_q;
  assign head_data = mem_q[head_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else if (flush) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (pop) head_q <= ~head_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC and RUN/END/FAULT control feeding a two-entry
// buffer toward decode, with branch redirect and misalignment trapping.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        branch_valid,
  input  logic [63:0] branch_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        done,
  output logic        fault
);

  localparam logic [63:0] MEM_LIMIT = 64'(IMEM_BYTES);
  localparam logic [63:0] STEP      = 64'(INSTR_BYTES);

  fetch_state_e       state_q;
  logic [63:0]        pc_q;
  logic [63:0]        pc_next;
  logic               done_q;
  logic               fault_q;
  logic               redirect;
  logic               target_aligned;
  logic               pop;
  logic               fetch;
  logic [1:0]         count;
  logic [ENTRY_W-1:0] head_data;

  assign pc_next        = pc_q + STEP;
  assign target_aligned = (branch_target[1:0] == 2'b00);
  // Redirects are dead once faulted; only reset recovers.
  assign redirect       = branch_valid && (state_q != FAULT);
  assign if_valid       = (count != 2'd0);
  assign pop            = if_valid && if_ready;
  assign fetch          = (state_q == RUN) && !branch_valid &&
                          ((count != 2'd2) || pop);

  fetch_fifo #(
    .DATA_W (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fetch),
    .pop       (pop),
    .flush     (redirect),
    .push_data ({pc_q, imem_data}),
    .count     (count),
    .head_data (head_data)
  );

  // Payload storage is unreset, so outputs are masked while the buffer is empty.
  assign if_instr  = if_valid ? head_data[INSTR_W-1:0] : '0;
  assign if_pc     = if_valid ? head_data[ENTRY_W-1:INSTR_W] : '0;
  assign imem_addr = pc_q;
  assign done      = done_q;
  assign fault     = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        RUN, END: begin
          if (redirect && !target_aligned) begin
            state_q <= FAULT;
            done_q  <= 1'b0;
            fault_q <= 1'b1;
          end else if (redirect) begin
            pc_q <= branch_target;
            if (branch_target >= MEM_LIMIT) begin
              state_q <= END;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              done_q  <= 1'b0;
            end
          end else if (fetch) begin
            pc_q <= pc_next;
            if (pc_next == MEM_LIMIT) begin
              state_q <= END;
              done_q  <= 1'b1;
            end
          end
        end
        FAULT: begin
          state_q <= FAULT;
          done_q  <= 1'b0;
          fault_q <= 1'b1;
        end
        default: begin
          state_q <= FAULT;
          done_q  <= 1'b0;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch against a queue-based reference model,
// plus directed scenarios for reset, streaming, backpressure, redirect, end and fault.
module tb_instr_fetch;

  localparam int IMEM = 64;
  localparam int M_RUN = 0, M_END = 1, M_FAULT = 2;

  logic        clk;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        branch_valid;
  logic [63:0] branch_target;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        done;
  logic        fault;

  instr_fetch #(.IMEM_BYTES(IMEM)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .done          (done),
    .fault         (fault)
  );

  logic [7:0] mem [IMEM];

  always_comb begin
    imem_data = 32'h0;
    if (imem_addr <= 64'(IMEM - 4))
      imem_data = {mem[imem_addr[5:0]], mem[imem_addr[5:0] + 6'd1],
                   mem[imem_addr[5:0] + 6'd2], mem[imem_addr[5:0] + 6'd3]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: architectural PC, mode and an ordered buffer of {pc, instr}.
  logic [63:0] m_pc;
  int          m_st;
  logic [95:0] m_q [$];

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mword(logic [63:0] a);
    int i;
    if (a > 64'(IMEM - 4)) return 32'h0;
    i = int'(a);
    return {mem[i], mem[i+1], mem[i+2], mem[i+3]};
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_st = M_RUN;
    m_q.delete();
  endtask

  task automatic compare_all();
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", if_valid, m_q.size() != 0);
    check_eq("if_instr", if_instr, m_q.size() != 0 ? {32'h0, m_q[0][31:0]} : 64'h0);
    check_eq("if_pc", if_pc, m_q.size() != 0 ? m_q[0][95:32] : 64'h0);
    check_eq("done", done, m_st == M_END);
    check_eq("fault", fault, m_st == M_FAULT);
  endtask

  // One clock: advance the model from the inputs held across the edge, then compare.
  task automatic step();
    bit pop, do_fetch;
    @(posedge clk);
    pop = (m_q.size() != 0) && if_ready;
    if (branch_valid && m_st != M_FAULT) begin
      m_q.delete();
      if (branch_target[1:0] != 2'b00) m_st = M_FAULT;
      else begin
        m_pc = branch_target;
        m_st = (branch_target >= 64'(IMEM)) ? M_END : M_RUN;
      end
    end else begin
      do_fetch = (m_st == M_RUN) && !branch_valid && (m_q.size() < 2 || pop);
      if (pop) void'(m_q.pop_front());
      if (do_fetch) begin
        m_q.push_back({m_pc, mword(m_pc)});
        m_pc = m_pc + 64'd4;
        if (m_pc == 64'(IMEM)) m_st = M_END;
      end
    end
    #1;
    compare_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_imem_addr", imem_addr, 64'h0);
    check_eq("rst_if_valid", if_valid, 1'b0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_if_pc", if_pc, 64'h0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_fault", fault, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    branch_valid = 1'b0;
  endtask

  initial begin
    int done_cyc;
    int drained;
    logic [63:0] last_pc;
    logic [63:0] tgt;
    int r;

    rst = 1'b1;
    branch_valid = 1'b0;
    branch_target = '0;
    if_ready = 1'b0;
    for (int i = 0; i < IMEM; i++) mem[i] = 8'($urandom);
    {mem[0], mem[1], mem[2], mem[3]}         = 32'hF840_0182;
    {mem[56], mem[57], mem[58], mem[59]}     = 32'h1400_0014;
    model_reset();
    #2;
    do_reset();

    // Streaming: first instruction one cycle after the fetch edge.
    if_ready = 1'b1;
    step();
    check_eq("stream_valid", if_valid, 1'b1);
    check_eq("stream_instr", if_instr, 32'hF840_0182);
    check_eq("stream_pc", if_pc, 64'h0);
    check_eq("stream_addr", imem_addr, 64'h4);
    repeat (3) step();

    // Mid-stream reset discards buffered instructions.
    #3;
    do_reset();

    // Backpressure from reset: buffer fills to two entries and PC parks at 8.
    if_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("bp_if_pc", if_pc, 64'h0);
    end
    check_eq("bp_addr", imem_addr, 64'h8);

    // Redirect with a full buffer.
    branch_valid = 1'b1;
    branch_target = 64'h38;
    step();
    check_eq("redir_flush", if_valid, 1'b0);
    branch_valid = 1'b0;
    step();
    check_eq("redir_pc", if_pc, 64'h38);
    check_eq("redir_instr", if_instr, 32'h1400_0014);
    if_ready = 1'b1;
    repeat (4) step();
    check_eq("redir_end_done", done, 1'b1);

    // End of memory: 16 fetches from 0, then the buffer drains.
    do_reset();
    if_ready = 1'b1;
    done_cyc = -1;
    last_pc = '1;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      step();
      if (if_valid) last_pc = if_pc;
      if (done) done_cyc = c;
    end
    check_eq("end_done_cycle", 64'(done_cyc), 64'd16);
    check_eq("end_last_pc", last_pc, 64'h3C);
    drained = 0;
    for (int c = 0; c < 10 && !drained; c++) begin
      step();
      if (!if_valid) drained = 1;
    end
    check_eq("end_drained", 64'(drained), 64'd1);
    check_eq("end_done_hold", done, 1'b1);

    // Misaligned redirect traps; later aligned redirect is ignored until reset.
    do_reset();
    if_ready = 1'b0;
    repeat (2) step();
    branch_valid = 1'b1;
    branch_target = 64'h06;
    step();
    check_eq("mis_fault", fault, 1'b1);
    check_eq("mis_valid", if_valid, 1'b0);
    branch_target = 64'h00;
    step();
    branch_valid = 1'b0;
    repeat (3) step();
    check_eq("mis_sticky", fault, 1'b1);
    check_eq("mis_addr_held", imem_addr, 64'h8);
    check_eq("mis_no_fetch", if_valid, 1'b0);
    do_reset();
    check_eq("mis_cleared", fault, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        #2;
        do_reset();
      end else begin
        if_ready = ($urandom_range(0, 9) < 7);
        branch_valid = ($urandom_range(0, 99) < 8);
        r = $urandom_range(0, 99);
        if (r < 3)       tgt = 64'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        else if (r < 12) tgt = 64'(IMEM + 4 * $urandom_range(0, 4));
        else             tgt = 64'(4 * $urandom_range(0, 15));
        branch_target = tgt;
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
